isqrt_rr_arbiter: RTL
=====================

Name: isqrt_rr_arbiter

Overview:
Shares one pipelined isqrt instance among N_REQ independent requesters, such as several formula FSMs.
- Round-robin arbitration; at most one issue per cycle.
- Each issued request is tagged with its requester index in an in-order tag FIFO.
- Each result is routed back to the requester that issued it.
- Sits between the requester FSMs' isqrt_x/isqrt_y interfaces and the single isqrt pipeline.

Parameters:
N_REQ, 4, number of requesters (2..8)
TAG_DEPTH, 16, max in-flight isqrt operations; must be >= isqrt pipeline latency + 1; power of two

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
req_vld  input  N_REQ  per-requester request valid; held until accepted
req_x  input  N_REQ*32  per-requester operand, requester i at bits [32*i+31:32*i]
req_rdy  output  N_REQ  per-requester grant; transfer when req_vld[i] & req_rdy[i]
rsp_vld  output  N_REQ  one-cycle result pulse to the owning requester
rsp_y  output  16  result value, valid when any rsp_vld bit is set
isqrt_x_vld  output  1  issue strobe to isqrt
isqrt_x  output  32  operand to isqrt
isqrt_y_vld  input  1  isqrt result valid; results return in issue order
isqrt_y  input  16  isqrt result
inflight  output  $clog2(TAG_DEPTH+1)  current tag FIFO occupancy
err_orphan  output  1  sticky: isqrt_y_vld arrived while tag FIFO empty

Behaviour:
- Reset (rst low, async) clears: rr_ptr=0, tag FIFO empty, inflight=0, rsp_vld=0, rsp_y=0, err_orphan=0. req_rdy=0 and isqrt_x_vld=0 while in reset.
- Arbitration is combinational within a cycle:
  - Search req_vld starting at index rr_ptr, wrapping modulo N_REQ; the first set bit i is the winner.
  - req_rdy is one-hot(i) only when the FIFO is not full (inflight < TAG_DEPTH); otherwise req_rdy = 0.
- Issue:
  - isqrt_x_vld = |(req_vld & req_rdy).
  - isqrt_x = req_x of the winner; 0 when not issuing. Zero latency from request to issue.
  - On issue: push tag i; rr_ptr <= (i+1) mod N_REQ.
  - With no issue, rr_ptr holds.
- Full FIFO:
  - No grant even if isqrt_y_vld pops in the same cycle; the conservative rule keeps grant off the result path.
  - Requests stall with req_vld held; no request is lost.
- Result:
  - On isqrt_y_vld with FIFO non-empty: pop head tag t.
  - Next cycle: rsp_vld = one-hot(t), rsp_y = isqrt_y (registered, latency 1 from isqrt_y_vld).
  - rsp_vld is low in every cycle without a result.
- Simultaneous issue and result in one cycle: push and pop both occur; inflight unchanged.
- Orphan result (isqrt_y_vld with FIFO empty):
  - No pop, no rsp_vld.
  - err_orphan <= 1; it clears only on reset.
- Reset mid-operation:
  - In-flight tags are discarded.
  - The isqrt instance must share the same reset; stale results after reset raise err_orphan.
- A requester may hold req_vld across many cycles with a changing rr_ptr. Fairness bound: any asserted request is granted within N_REQ grant cycles.
- A requester may have multiple operations in flight. Its results arrive in its own issue order.
- Widths: the operand passes unmodified (32b); the result passes 16b unmodified; no arithmetic in this block.

Decomposition:
- Package isqrt_arb_pkg holds:
  - ISQRT_X_W=32 and ISQRT_Y_W=16
  - default N_REQ and TAG_DEPTH
  - tag_t as logic [$clog2(N_REQ)-1:0]
- Sub-module isqrt_tag_fifo: synchronous FIFO of tag_t, depth TAG_DEPTH.
  - Async active-low reset.
  - push/pop/full/empty/count ports.
  - Simultaneous push and pop are legal when the FIFO is non-empty.
- Arbiter logic, result register and error flag stay in isqrt_rr_arbiter.

Test Plan:
- Single requester: req_vld[2]=1, x=144, isqrt model latency 4 -> req_rdy[2] in the same cycle; isqrt_x=144; 5 cycles later rsp_vld=4'b0100, rsp_y=12.
- All four requesters assert together with x=1,4,9,16, rr_ptr=0 -> grants in order 0,1,2,3 on consecutive cycles; responses 1,2,3,4 arrive with rsp_vld one-hot 0,1,2,3.
- Fairness: requester 0 always asserted, requester 3 asserts once -> requester 3 is granted within 4 cycles; grants alternate after rr_ptr passes index 0.
- FIFO full: TAG_DEPTH=4, isqrt model stalls results -> after 4 issues req_rdy=0 and inflight=4; first result releases a grant the following cycle; no request is lost.
- Simultaneous issue+pop: continuous traffic with latency 3 -> inflight stays constant at 3; every rsp_vld matches the issuing tag.
- Orphan and reset: inject isqrt_y_vld with FIFO empty -> err_orphan=1, no rsp_vld. Assert rst low mid-flight -> inflight=0, err_orphan=0, rsp_vld=0 asynchronously.

Source files
------------

// File: rtl/isqrt_arb_pkg.sv
// Shared widths, default sizing and the requester tag type for the
// isqrt round-robin arbiter slice.
package isqrt_arb_pkg;

    localparam int unsigned ISQRT_X_W     = 32;
    localparam int unsigned ISQRT_Y_W     = 16;
    localparam int unsigned DEF_N_REQ     = 4;
    localparam int unsigned DEF_TAG_DEPTH = 16;

    typedef logic [$clog2(DEF_N_REQ)-1:0] tag_t;

endpackage

// File: rtl/isqrt_tag_fifo.sv
// In-order FIFO of requester tags, one entry per isqrt operation in flight.
// Push and pop in the same cycle are legal when the FIFO holds at least one entry.
module isqrt_tag_fifo
    import isqrt_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_TAG_DEPTH,
    parameter int unsigned TAG_W = $bits(tag_t),
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] pop_tag,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_tag = mem[rd_ptr];

    // Storage carries no reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_tag;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/isqrt_rr_arbiter.sv
// Round-robin sharing of one pipelined isqrt among N_REQ requesters; each
// issue is tagged in order so results are routed back to their owner.
module isqrt_rr_arbiter
    import isqrt_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = DEF_N_REQ,
    parameter int unsigned TAG_DEPTH = DEF_TAG_DEPTH,
    localparam int unsigned PTR_W    = $clog2(N_REQ),
    localparam int unsigned CNT_W    = $clog2(TAG_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_vld,
    input  logic [N_REQ*ISQRT_X_W-1:0] req_x,
    output logic [N_REQ-1:0]           req_rdy,
    output logic [N_REQ-1:0]           rsp_vld,
    output logic [ISQRT_Y_W-1:0]       rsp_y,
    output logic                       isqrt_x_vld,
    output logic [ISQRT_X_W-1:0]       isqrt_x,
    input  logic                       isqrt_y_vld,
    input  logic [ISQRT_Y_W-1:0]       isqrt_y,
    output logic [CNT_W-1:0]           inflight,
    output logic                       err_orphan
);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] cand;
    logic [PTR_W-1:0] win_idx;
    logic             win_found;
    logic             issue;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PTR_W-1:0] head_tag;
    logic [N_REQ-1:0] head_onehot;

    // First asserted request at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = PTR_W'((32'(rr_ptr) + off) % N_REQ);
            if (!win_found && req_vld[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Grant looks only at occupancy, never at this cycle's pop, so the
    // result return path stays out of the grant timing.
    always_comb begin
        req_rdy = '0;
        if (rst && win_found && !fifo_full)
            req_rdy[win_idx] = 1'b1;
    end

    assign issue       = |(req_vld & req_rdy);
    assign isqrt_x_vld = issue;

    always_comb begin
        isqrt_x = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (issue && win_idx == PTR_W'(i))
                isqrt_x = req_x[i*ISQRT_X_W +: ISQRT_X_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_ptr <= '0;
        else if (issue)
            rr_ptr <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end

    assign pop = isqrt_y_vld && !fifo_empty;

    isqrt_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .TAG_W (PTR_W)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (issue),
        .push_tag (win_idx),
        .pop      (pop),
        .pop_tag  (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (inflight)
    );

    always_comb begin
        head_onehot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (head_tag == PTR_W'(i))
                head_onehot[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_vld    <= '0;
            rsp_y      <= '0;
            err_orphan <= 1'b0;
        end else begin
            rsp_vld <= pop ? head_onehot : '0;
            if (pop)
                rsp_y <= isqrt_y;
            if (isqrt_y_vld && fifo_empty)
                err_orphan <= 1'b1;
        end
    end

endmodule
